// File: rtl/dds_pkg.sv
// Shared types and constants for the DDS frequency-sweep sequencer.
// Fword constants assume a 50 MHz sys_clk and a 32-bit phase accumulator.
package dds_pkg;

  localparam int FW_W_DEF = 32;
  localparam int PW_W_DEF = 12;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_DWELL = 3'd2,
    ST_STEP  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [1:0] MODE_SINGLE = 2'b00;
  localparam logic [1:0] MODE_SAW    = 2'b01;
  localparam logic [1:0] MODE_TRI    = 2'b10;

  localparam logic [31:0] F_100 = 32'd8590;
  localparam logic [31:0] F_300 = 32'd25770;
  localparam logic [31:0] F_1k  = 32'd85899;
  localparam logic [31:0] F_3k  = 32'd257698;
  localparam logic [31:0] F_10k = 32'd858993;

  // Mode 11 is not a distinct sweep; it behaves as a single sweep.
  function automatic logic [1:0] eff_mode(input logic [1:0] mode);
    return ((mode == MODE_SAW) || (mode == MODE_TRI)) ? mode : MODE_SINGLE;
  endfunction

endpackage

// File: rtl/dds_dwell_timer.sv
// Loadable down-counter that saturates at zero; flags zero so the sweep
// sequencer knows when the current point has been held long enough.
module dds_dwell_timer #(
  parameter int DWELL_W = 24
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_load,
  input  logic [DWELL_W-1:0] i_load_val,
  output logic               o_zero
);

  logic [DWELL_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= {DWELL_W{1'b0}};
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != {DWELL_W{1'b0}}) begin
      r_cnt <= r_cnt - {{(DWELL_W-1){1'b0}}, 1'b1};
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_zero = (r_cnt == {DWELL_W{1'b0}});

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer driving the DDS core Fword/Pword inputs.
// Every point is held cfg_dwell+1 cycles; the STEP cycle is the last one.
import dds_pkg::*;

module dds_sweep_ctrl #(
  parameter int FW_W    = 32,
  parameter int PW_W    = 12,
  parameter int DWELL_W = 24,
  parameter int FW_RST  = 8590
) (
  input  logic               sys_clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [FW_W-1:0]    cfg_f_start,
  input  logic [FW_W-1:0]    cfg_f_stop,
  input  logic [FW_W-1:0]    cfg_f_step,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic [1:0]         cfg_mode,
  input  logic [PW_W-1:0]    cfg_pword,
  output logic [FW_W-1:0]    Fword,
  output logic [PW_W-1:0]    Pword,
  output logic               fword_upd,
  output logic               busy,
  output logic               sweep_done,
  output logic               cfg_err
);

  state_t r_state, w_state_nxt, w_point_st;
  logic [FW_W-1:0] r_fword, w_fword_nxt;
  logic [PW_W-1:0] r_pword, w_pword_nxt;
  logic r_dir_up, w_dir_up_nxt;
  logic r_upd, w_upd_nxt, r_busy, w_busy_nxt, r_done, w_done_nxt, r_err, w_err_nxt;
  logic w_latch, w_tmr_load, w_tmr_zero, w_cfg_bad;
  logic [FW_W-1:0] r_f_start, r_f_stop, r_f_step, w_up_val, w_dn_val;
  logic [DWELL_W-1:0] r_dwell;
  logic [1:0] r_mode;
  logic [PW_W-1:0] r_pword_sh;
  logic [FW_W:0] w_sum, w_diff;

  // Timer holds dwell-1 because the STEP cycle itself is the final cycle of a point.
  dds_dwell_timer #(.DWELL_W(DWELL_W)) u_dwell_timer (
    .i_clk      (sys_clk),
    .i_rst      (rst),
    .i_load     (w_tmr_load),
    .i_load_val (r_dwell - {{(DWELL_W-1){1'b0}}, 1'b1}),
    .o_zero     (w_tmr_zero)
  );

  assign w_cfg_bad  = (cfg_f_start > cfg_f_stop) || (cfg_f_step == {FW_W{1'b0}});
  assign w_point_st = (r_dwell == {DWELL_W{1'b0}}) ? ST_STEP : ST_DWELL;
  assign w_sum      = {1'b0, r_fword} + {1'b0, r_f_step};
  assign w_diff     = {1'b0, r_fword} - {1'b0, r_f_step};
  assign w_up_val   = (w_sum[FW_W] || (w_sum[FW_W-1:0] >= r_f_stop)) ? r_f_stop : w_sum[FW_W-1:0];
  assign w_dn_val   = (w_diff[FW_W] || (w_diff[FW_W-1:0] <= r_f_start)) ? r_f_start : w_diff[FW_W-1:0];

  always_comb begin
    w_state_nxt  = r_state;
    w_fword_nxt  = r_fword;
    w_pword_nxt  = r_pword;
    w_dir_up_nxt = r_dir_up;
    w_busy_nxt   = r_busy;
    w_upd_nxt    = 1'b0;
    w_done_nxt   = 1'b0;
    w_err_nxt    = 1'b0;
    w_latch      = 1'b0;
    w_tmr_load   = 1'b0;
    if (abort) begin
      w_state_nxt = ST_IDLE;
      w_busy_nxt  = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start && w_cfg_bad) begin
            w_err_nxt = 1'b1;
          end else if (start) begin
            w_latch     = 1'b1;
            w_busy_nxt  = 1'b1;
            w_state_nxt = ST_LOAD;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_LOAD: begin
          w_fword_nxt  = r_f_start;
          w_pword_nxt  = r_pword_sh;
          w_upd_nxt    = 1'b1;
          w_dir_up_nxt = 1'b1;
          w_tmr_load   = 1'b1;
          w_state_nxt  = w_point_st;
        end
        ST_DWELL: begin
          if (w_tmr_zero) begin
            w_state_nxt = ST_STEP;
          end else begin
            w_state_nxt = ST_DWELL;
          end
        end
        ST_STEP: begin
          w_upd_nxt   = 1'b1;
          w_tmr_load  = 1'b1;
          w_state_nxt = w_point_st;
          if (r_dir_up && (r_fword < r_f_stop)) begin
            w_fword_nxt = w_up_val;
          end else if (r_dir_up) begin
            case (eff_mode(r_mode))
              MODE_SAW: w_fword_nxt = r_f_start;
              MODE_TRI: begin
                w_dir_up_nxt = 1'b0;
                w_fword_nxt  = w_dn_val;
              end
              default: begin
                w_upd_nxt   = 1'b0;
                w_tmr_load  = 1'b0;
                w_busy_nxt  = 1'b0;
                w_done_nxt  = 1'b1;
                w_state_nxt = ST_DONE;
              end
            endcase
          end else if (r_fword > r_f_start) begin
            w_fword_nxt = w_dn_val;
          end else if (r_fword < r_f_stop) begin
            w_dir_up_nxt = 1'b1;
            w_fword_nxt  = w_up_val;
          end else begin
            // Degenerate range: the point repeats but still counts as an update.
            w_fword_nxt = r_f_start;
          end
        end
        ST_DONE: w_state_nxt = ST_IDLE;
        default: begin
          w_state_nxt = ST_IDLE;
          w_busy_nxt  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_fword    <= FW_W'(FW_RST);
      r_pword    <= {PW_W{1'b0}};
      r_dir_up   <= 1'b1;
      r_busy     <= 1'b0;
      r_upd      <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_f_start  <= {FW_W{1'b0}};
      r_f_stop   <= {FW_W{1'b0}};
      r_f_step   <= {FW_W{1'b0}};
      r_dwell    <= {DWELL_W{1'b0}};
      r_mode     <= MODE_SINGLE;
      r_pword_sh <= {PW_W{1'b0}};
    end else begin
      r_state  <= w_state_nxt;
      r_fword  <= w_fword_nxt;
      r_pword  <= w_pword_nxt;
      r_dir_up <= w_dir_up_nxt;
      r_busy   <= w_busy_nxt;
      r_upd    <= w_upd_nxt;
      r_done   <= w_done_nxt;
      r_err    <= w_err_nxt;
      if (w_latch) begin
        r_f_start  <= cfg_f_start;
        r_f_stop   <= cfg_f_stop;
        r_f_step   <= cfg_f_step;
        r_dwell    <= cfg_dwell;
        r_mode     <= cfg_mode;
        r_pword_sh <= cfg_pword;
      end else begin
        r_f_start  <= r_f_start;
        r_f_stop   <= r_f_stop;
        r_f_step   <= r_f_step;
        r_dwell    <= r_dwell;
        r_mode     <= r_mode;
        r_pword_sh <= r_pword_sh;
      end
    end
  end

  assign Fword      = r_fword;
  assign Pword      = r_pword;
  assign fword_upd  = r_upd;
  assign busy       = r_busy;
  assign sweep_done = r_done;
  assign cfg_err    = r_err;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Self-checking bench for dds_sweep_ctrl: directed vector table, hand-written
// abort/reset sequences and randomized sweeps against a point-list model.
module tb_dds_sweep_ctrl;

  logic        sys_clk = 1'b0;
  logic        rst, start, abort;
  logic [31:0] cfg_f_start, cfg_f_stop, cfg_f_step;
  logic [23:0] cfg_dwell;
  logic [1:0]  cfg_mode;
  logic [11:0] cfg_pword;
  logic [31:0] Fword;
  logic [11:0] Pword;
  logic        fword_upd, busy, sweep_done, cfg_err;

  always #5 sys_clk = ~sys_clk;

  dds_sweep_ctrl dut (
    .sys_clk(sys_clk), .rst(rst), .start(start), .abort(abort),
    .cfg_f_start(cfg_f_start), .cfg_f_stop(cfg_f_stop), .cfg_f_step(cfg_f_step),
    .cfg_dwell(cfg_dwell), .cfg_mode(cfg_mode), .cfg_pword(cfg_pword),
    .Fword(Fword), .Pword(Pword), .fword_upd(fword_upd), .busy(busy),
    .sweep_done(sweep_done), .cfg_err(cfg_err)
  );

  typedef struct packed {
    logic [31:0] fs, fe, st;
    logic [23:0] dw;
    logic [1:0]  md;
    logic        bad;
    logic [3:0]  n;
    logic [3:0][31:0] p;
  } vec_t;

  localparam int NV = 7;
  vec_t vt [NV];
  int checks = 0;
  int failures = 0;
  logic [31:0] exp_fw;
  logic [11:0] exp_pw;
  logic [31:0] mq [$];

  function automatic vec_t mkv(input logic [31:0] fs, fe, st, input logic [23:0] dw,
                               input logic [1:0] md, input logic bad, input logic [3:0] n,
                               input logic [31:0] p0, p1, p2, p3);
    vec_t v;
    v.fs = fs; v.fe = fe; v.st = st; v.dw = dw; v.md = md; v.bad = bad; v.n = n;
    v.p[0] = p0; v.p[1] = p1; v.p[2] = p2; v.p[3] = p3;
    return v;
  endfunction

  task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", nm, c, act, exp);
    end
  endtask

  // Reference: the list of sweep points derived from the start/stop/step rules.
  task automatic build_model(input logic [31:0] fs, fe, st, input logic [1:0] md, input int nmin);
    logic [63:0] v;
    logic [31:0] a [$];
    logic [31:0] d [$];
    mq.delete();
    v = 64'(fs);
    while (1) begin
      a.push_back(v[31:0]);
      if (v == 64'(fe)) break;
      v = (v + 64'(st) >= 64'(fe)) ? 64'(fe) : v + 64'(st);
    end
    v = 64'(fe);
    while (1) begin
      d.push_back(v[31:0]);
      if (v == 64'(fs)) break;
      v = (v <= 64'(fs) + 64'(st)) ? 64'(fs) : v - 64'(st);
    end
    if (md == 2'b01) begin
      while (mq.size() < nmin) foreach (a[i]) mq.push_back(a[i]);
    end else if (md == 2'b10) begin
      if (fs == fe) begin
        while (mq.size() < nmin) mq.push_back(fs);
      end else begin
        foreach (a[i]) mq.push_back(a[i]);
        while (mq.size() < nmin) begin
          for (int i = 1; i < d.size(); i++) mq.push_back(d[i]);
          for (int i = 1; i < a.size(); i++) mq.push_back(a[i]);
        end
      end
    end else begin
      foreach (a[i]) mq.push_back(a[i]);
    end
  endtask

  // Start a sweep, then compare every cycle against the expected point list in mq.
  task automatic run_seq(input logic [31:0] fs, fe, st, input logic [23:0] dw, input logic [1:0] md,
                         input logic [11:0] pw, input bit use_model, input int npts,
                         input int abort_c, input int poke_c);
    bit single;
    int per, n, last_c, k, idx, ph;
    logic [31:0] e_fw, fz_fw;
    logic [11:0] e_pw, fz_pw;
    logic e_upd, e_busy, e_done;
    single = (md == 2'b00) || (md == 2'b11);
    per = int'(dw) + 1;
    if (use_model) build_model(fs, fe, st, md, npts);
    n = mq.size();
    last_c = single ? (2 + n * per + 2) : (abort_c + 2);
    fz_fw = exp_fw; fz_pw = exp_pw;
    cfg_f_start = fs; cfg_f_stop = fe; cfg_f_step = st; cfg_dwell = dw; cfg_mode = md; cfg_pword = pw;
    start = 1'b1;
    @(posedge sys_clk); #1;
    start = 1'b0;
    cfg_f_start = $urandom; cfg_f_stop = $urandom; cfg_f_step = $urandom;
    cfg_dwell = 24'($urandom); cfg_mode = 2'($urandom); cfg_pword = 12'($urandom);
    for (int c = 1; c <= last_c; c++) begin
      @(negedge sys_clk);
      start = 1'b0; abort = 1'b0;
      e_upd = 1'b0; e_done = 1'b0; e_busy = 1'b1; e_fw = exp_fw; e_pw = exp_pw;
      if (abort_c > 0 && c > abort_c) begin
        e_fw = fz_fw; e_pw = fz_pw; e_busy = 1'b0;
      end else if (c >= 2) begin
        k = c - 2; idx = k / per; ph = k % per; e_pw = pw;
        if (idx < n) begin
          e_fw = mq[idx]; e_upd = (ph == 0);
        end else begin
          e_fw = mq[n-1]; e_busy = 1'b0; e_done = (idx == n) && (ph == 0);
        end
      end
      chk("fword", c, Fword, e_fw);
      chk("pword", c, 32'(Pword), 32'(e_pw));
      chk("fword_upd", c, 32'(fword_upd), 32'(e_upd));
      chk("busy", c, 32'(busy), 32'(e_busy));
      chk("sweep_done", c, 32'(sweep_done), 32'(e_done));
      chk("cfg_err_busy", c, 32'(cfg_err), 32'd0);
      if (c == abort_c) begin fz_fw = e_fw; fz_pw = e_pw; abort = 1'b1; end
      if (c == poke_c) begin start = 1'b1; cfg_f_step = 32'd0; end
    end
    start = 1'b0; abort = 1'b0;
    if (abort_c > 0) begin exp_fw = fz_fw; exp_pw = fz_pw; end
    else begin exp_fw = mq[n-1]; exp_pw = pw; end
  endtask

  task automatic load_tab(input int i);
    mq.delete();
    for (int j = 0; j < int'(vt[i].n); j++) mq.push_back(vt[i].p[j]);
  endtask

  initial begin
    logic [31:0] fs, fe, st;
    logic [63:0] top;
    int span, per, npts, ac, n, pc;
    logic [1:0] md;
    logic [23:0] dw;

    vt[0] = mkv(32'd500, 32'd100, 32'd1, 24'd0, 2'b00, 1'b1, 4'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    vt[1] = mkv(32'd100, 32'd400, 32'd0, 24'd0, 2'b00, 1'b1, 4'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    vt[2] = mkv(32'd100, 32'd400, 32'd100, 24'd3, 2'b00, 1'b0, 4'd4, 32'd100, 32'd200, 32'd300, 32'd400);
    vt[3] = mkv(32'd100, 32'd350, 32'd100, 24'd0, 2'b00, 1'b0, 4'd4, 32'd100, 32'd200, 32'd300, 32'd350);
    vt[4] = mkv(32'hFFFFFF00, 32'hFFFFFFFF, 32'h80, 24'd2, 2'b00, 1'b0, 4'd3,
                32'hFFFFFF00, 32'hFFFFFF80, 32'hFFFFFFFF, 32'd0);
    vt[5] = mkv(32'd10, 32'd30, 32'd7, 24'd1, 2'b11, 1'b0, 4'd4, 32'd10, 32'd17, 32'd24, 32'd30);
    vt[6] = mkv(32'd42, 32'd42, 32'd5, 24'd1, 2'b00, 1'b0, 4'd1, 32'd42, 32'd0, 32'd0, 32'd0);

    rst = 1'b1; start = 1'b0; abort = 1'b0;
    cfg_f_start = 32'd0; cfg_f_stop = 32'd0; cfg_f_step = 32'd0;
    cfg_dwell = 24'd0; cfg_mode = 2'b00; cfg_pword = 12'd0;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    chk("rst_fword", 0, Fword, 32'd8590);
    chk("rst_pword", 0, 32'(Pword), 32'd0);
    chk("rst_busy", 0, 32'(busy), 32'd0);
    chk("rst_upd", 0, 32'(fword_upd), 32'd0);
    chk("rst_done", 0, 32'(sweep_done), 32'd0);
    chk("rst_err", 0, 32'(cfg_err), 32'd0);
    rst = 1'b0; exp_fw = 32'd8590; exp_pw = 12'd0;

    for (int i = 0; i < NV; i++) begin
      if (vt[i].bad) begin
        cfg_f_start = vt[i].fs; cfg_f_stop = vt[i].fe; cfg_f_step = vt[i].st;
        cfg_dwell = vt[i].dw; cfg_mode = vt[i].md; start = 1'b1;
        @(posedge sys_clk); #1; start = 1'b0;
        @(negedge sys_clk);
        chk("bad_err", i, 32'(cfg_err), 32'd1);
        chk("bad_busy", i, 32'(busy), 32'd0);
        chk("bad_fword", i, Fword, exp_fw);
        @(negedge sys_clk);
        chk("bad_err_pulse", i, 32'(cfg_err), 32'd0);
        chk("bad_busy2", i, 32'(busy), 32'd0);
        chk("bad_upd", i, 32'(fword_upd), 32'd0);
      end else begin
        load_tab(i);
        run_seq(vt[i].fs, vt[i].fe, vt[i].st, vt[i].dw, vt[i].md, 12'(i * 291), 1'b0, 0, 0, 3);
      end
    end

    // Triangle 100/300/100 with abort part-way into the sixth point.
    run_seq(32'd100, 32'd300, 32'd100, 24'd1, 2'b10, 12'h3C3, 1'b1, 8, 13, 6);

    // Abort and start together: start must be ignored.
    cfg_f_start = 32'd100; cfg_f_stop = 32'd400; cfg_f_step = 32'd100; cfg_dwell = 24'd0;
    cfg_mode = 2'b00; start = 1'b1; abort = 1'b1;
    @(posedge sys_clk); #1; start = 1'b0; abort = 1'b0;
    @(negedge sys_clk);
    chk("abst_busy", 1, 32'(busy), 32'd0);
    chk("abst_err", 1, 32'(cfg_err), 32'd0);
    @(negedge sys_clk);
    chk("abst_busy2", 2, 32'(busy), 32'd0);
    chk("abst_upd", 2, 32'(fword_upd), 32'd0);
    chk("abst_fword", 2, Fword, exp_fw);

    // Reset in the middle of a sawtooth dwell, then a fresh single sweep.
    cfg_f_start = 32'd100; cfg_f_stop = 32'd400; cfg_f_step = 32'd100; cfg_dwell = 24'd3;
    cfg_mode = 2'b01; cfg_pword = 12'h5A5; start = 1'b1;
    @(posedge sys_clk); #1; start = 1'b0;
    repeat (7) @(negedge sys_clk);
    chk("pre_rst_busy", 7, 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge sys_clk);
    rst = 1'b0;
    chk("mrst_fword", 0, Fword, 32'd8590);
    chk("mrst_pword", 0, 32'(Pword), 32'd0);
    chk("mrst_busy", 0, 32'(busy), 32'd0);
    chk("mrst_upd", 0, 32'(fword_upd), 32'd0);
    exp_fw = 32'd8590; exp_pw = 12'd0;
    @(negedge sys_clk);
    load_tab(2);
    run_seq(32'd100, 32'd400, 32'd100, 24'd3, 2'b00, 12'h0A0, 1'b0, 0, 0, 0);

    for (int r = 0; r < 40; r++) begin
      fs = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF - 32'($urandom_range(0, 4000)) : 32'($urandom_range(0, 100000));
      span = $urandom_range(0, 5000);
      top = 64'(fs) + 64'(span);
      fe = (top > 64'hFFFFFFFF) ? 32'hFFFFFFFF : top[31:0];
      st = 32'(span / $urandom_range(1, 8)) + 32'($urandom_range(1, 50));
      md = 2'($urandom_range(0, 3));
      dw = 24'($urandom_range(0, 3));
      per = int'(dw) + 1;
      if (md == 2'b01 || md == 2'b10) begin
        npts = $urandom_range(3, 12);
        ac = $urandom_range(1, 1 + npts * per);
        pc = $urandom_range(1, ac);
        run_seq(fs, fe, st, dw, md, 12'($urandom), 1'b1, npts, ac, pc);
      end else begin
        build_model(fs, fe, st, md, 0);
        n = mq.size();
        pc = $urandom_range(1, 1 + n * per);
        run_seq(fs, fe, st, dw, md, 12'($urandom), 1'b0, 0, 0, pc);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
